// File: rtl/dx_latch.sv
// rtl/dx_latch.sv - decode->execute pipeline register with flush bubbles; optional bubble counter under DX_BUBBLE_COUNT_EN
module dx_latch #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic              stall,
  input  logic              dx_flush,
  input  logic              fd_valid,
  input  logic [31:0]       fd_instr,
  input  logic [31:0]       fd_npc,
  input  logic [31:0]       fd_rdat1,
  input  logic [31:0]       fd_rdat2,
  input  logic [4:0]        fd_dest,
  input  logic              fd_rfWEN,
  input  logic [CTRL_W-1:0] fd_ctrl,
  output logic              ex_valid,
  output logic [31:0]       ex_instr,
  output logic [31:0]       ex_npc,
  output logic [31:0]       ex_rdat1,
  output logic [31:0]       ex_rdat2,
  output logic [4:0]        ex_dest,
  output logic              ex_rfWEN,
  output logic [CTRL_W-1:0] ex_ctrl
`ifdef DX_BUBBLE_COUNT_EN
  ,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  logic adv;
  logic load_bubble;
  logic flush_pending;

  // A stall overrides a fetch hit; a flush seen during a fetch miss is remembered.
  assign adv         = en & ~stall;
  assign load_bubble = adv & (dx_flush | flush_pending);

  // Pipeline register: bubble, real capture, or hold (remembering flushes across misses).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ex_valid      <= 1'b0;
      ex_instr      <= 32'h0;
      ex_npc        <= 32'h0;
      ex_rdat1      <= 32'h0;
      ex_rdat2      <= 32'h0;
      ex_dest       <= 5'd0;
      ex_rfWEN      <= 1'b0;
      ex_ctrl       <= '0;
      flush_pending <= 1'b0;
    end else if (load_bubble) begin
      ex_valid      <= 1'b0;
      ex_instr      <= 32'h0;
      ex_npc        <= 32'h0;
      ex_rdat1      <= 32'h0;
      ex_rdat2      <= 32'h0;
      ex_dest       <= 5'd0;
      ex_rfWEN      <= 1'b0;
      ex_ctrl       <= '0;
      flush_pending <= 1'b0;
    end else if (adv) begin
      ex_valid      <= fd_valid;
      ex_instr      <= fd_instr;
      ex_npc        <= fd_npc;
      ex_rdat1      <= fd_rdat1;
      ex_rdat2      <= fd_rdat2;
      ex_dest       <= fd_dest;
      // An invalid slot must never write the register file.
      ex_rfWEN      <= fd_rfWEN & fd_valid;
      ex_ctrl       <= fd_ctrl;
    end else if (!stall && dx_flush) begin
      flush_pending <= 1'b1;
    end
  end

`ifdef DX_BUBBLE_COUNT_EN
  // Saturating count of bubbles inserted; only reset clears it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bubble_cnt <= '0;
    end else if (load_bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
